ps2_tx: RTL and testbench

- PS/2 host-to-device transmitter. It is the send-side counterpart of the keyboard receiver.
- Sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable).
- Drives the open-drain PS/2 clock and data lines through active-high pull-low enables. The top level merges these enables into the ps2 pins.
- Runs in the 7 MHz enable domain (ce70n), beside the keyboard block.

---
 rtl/ps2_tx.sv | 223 ++++++++++++++++++++++
 tb/tb_ps2_tx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
//-----------------------------------------------------------------------------
// ps2_tx - PS/2 host-to-device transmitter.
//
// Sends one command byte (e.g. 0xED set LEDs, 0xFF reset, 0xF4 enable) to a
// PS/2 device. Both PS/2 lines are open-drain. This block only produces
// active-high pull-low enables, and the top level merges them into the pins.
// All state advances on ce ticks (the 7 MHz enable domain). Reset is the
// exception: it acts on any clock edge.
//
// Frame: the host holds the clock low for INHIBIT ticks, then pulls data low
// (start bit) and releases the clock. The device then clocks 11 pulses. The
// host changes data after each falling edge (8 data bits LSB first, odd
// parity, then releases data for the stop bit). On the 11th falling edge it
// samples the device's ack. A TIMEOUT guard covers the device-clocked part.
//
// Ports:
//   clock    in   system clock
//   reset    in   synchronous active-low reset
//   ce       in   clock enable (7 MHz tick)
//   ps2Ck    in   raw PS/2 clock read back from the pin
//   ps2Da    in   raw PS/2 data read back from the pin
//   ps2CkOe  out  1 pulls the PS/2 clock line low
//   ps2DaOe  out  1 pulls the PS/2 data line low
//   req      in   start a transmission (sampled on ce ticks, ignored while busy)
//   di[7:0]  in   byte to send, latched when req is accepted
//   busy     out  high from req acceptance until return to IDLE
//   done     out  one-ce-period pulse: device acknowledged the byte
//   error    out  one-ce-period pulse: NACK or timeout
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module ps2_tx #(
  parameter int INHIBIT = 700,     // clock-low ticks before the start bit
  parameter int TIMEOUT = 105000   // ticks from clock release to ack
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       ps2Ck,
  input  logic       ps2Da,
  output logic       ps2CkOe,
  output logic       ps2DaOe,
  input  logic       req,
  input  logic [7:0] di,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int               CNT_W      = (INHIBIT > 1) ? $clog2(INHIBIT) : 1;
  localparam logic [CNT_W-1:0] INHIB_LAST = CNT_W'(INHIBIT - 1);
  localparam logic [16:0]      TMO_LAST   = 17'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, INHIB, REL, XFER, ACK} state_t;

  state_t           r_state, w_state;
  logic             r_ck_meta, r_ck_sync, r_ck_prev;
  logic             r_da_meta, r_da_sync;
  logic [7:0]       r_sh, w_sh;
  logic             r_par, w_par;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [3:0]       r_bit, w_bit;
  logic [16:0]      r_tmo, w_tmo;
  logic             r_ck_oe, w_ck_oe;
  logic             r_da_oe, w_da_oe;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_error, w_error;

  logic             w_fall;
  logic             w_tmo_hit;

  assign w_fall    = r_ck_prev & ~r_ck_sync;
  assign w_tmo_hit = (r_tmo == TMO_LAST);

  // Every register is reset, including the data latches, so a reset in the
  // middle of a frame releases both lines on that same edge.
  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_ck_meta <= 1'b0;
      r_ck_sync <= 1'b0;
      r_ck_prev <= 1'b0;
      r_da_meta <= 1'b0;
      r_da_sync <= 1'b0;
      r_sh      <= '0;
      r_par     <= 1'b0;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_tmo     <= '0;
      r_ck_oe   <= 1'b0;
      r_da_oe   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else if (ce) begin
      r_ck_meta <= ps2Ck;
      r_ck_sync <= r_ck_meta;
      r_ck_prev <= r_ck_sync;
      r_da_meta <= ps2Da;
      r_da_sync <= r_da_meta;
      r_state   <= w_state;
      r_sh      <= w_sh;
      r_par     <= w_par;
      r_cnt     <= w_cnt;
      r_bit     <= w_bit;
      r_tmo     <= w_tmo;
      r_ck_oe   <= w_ck_oe;
      r_da_oe   <= w_da_oe;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_error   <= w_error;
    end
  end

  // NOTE: every signal gets a default before the case, so no path through
  // this block leaves one unassigned (which would infer a latch).
  always_comb begin
    w_state = r_state;
    w_sh    = r_sh;
    w_par   = r_par;
    w_cnt   = r_cnt;
    w_bit   = r_bit;
    w_tmo   = r_tmo;
    w_ck_oe = r_ck_oe;
    w_da_oe = r_da_oe;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_error = 1'b0;

    case (r_state)
      IDLE: begin
        w_busy  = 1'b0;
        w_ck_oe = 1'b0;
        w_da_oe = 1'b0;
        if (req) begin
          w_sh    = di;
          w_par   = ~^di;          // odd parity
          w_busy  = 1'b1;
          w_ck_oe = 1'b1;          // inhibit: hold the clock low
          w_cnt   = '0;
          w_state = INHIB;
        end
      end

      INHIB: begin
        w_cnt = r_cnt + CNT_W'(1);
        if (r_cnt == INHIB_LAST) begin
          w_da_oe = 1'b1;          // start bit
          w_state = REL;
        end
      end

      REL: begin
        w_ck_oe = 1'b0;            // hand the clock over to the device
        w_bit   = '0;
        w_tmo   = '0;
        w_state = XFER;
      end

      XFER: begin
        w_tmo = r_tmo + 17'd1;
        if (w_tmo_hit) begin
          w_error = 1'b1;
          w_ck_oe = 1'b0;
          w_da_oe = 1'b0;
          w_busy  = 1'b0;
          w_state = IDLE;
        end else if (w_fall) begin
          w_bit = r_bit + 4'd1;
          case (r_bit)
            4'd8:    w_da_oe = ~r_par;
            4'd9:    w_da_oe = 1'b0;   // stop bit: release data
            4'd10: begin
              // The device pulls data low to acknowledge the frame.
              if (!r_da_sync) begin
                w_state = ACK;
              end else begin
                w_error = 1'b1;
                w_ck_oe = 1'b0;
                w_da_oe = 1'b0;
                w_busy  = 1'b0;
                w_state = IDLE;
              end
            end
            default: if (r_bit < 4'd8) w_da_oe = ~r_sh[r_bit[2:0]];
          endcase
        end
      end

      ACK: begin
        w_tmo = r_tmo + 17'd1;
        if (w_tmo_hit) begin
          w_error = 1'b1;
          w_ck_oe = 1'b0;
          w_da_oe = 1'b0;
          w_busy  = 1'b0;
          w_state = IDLE;
        end else if (r_ck_sync && r_da_sync) begin
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_state = IDLE;
        end
      end

      default: begin
        w_ck_oe = 1'b0;
        w_da_oe = 1'b0;
        w_busy  = 1'b0;
        w_state = IDLE;
      end
    endcase
  end

  assign ps2CkOe = r_ck_oe;
  assign ps2DaOe = r_da_oe;
  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_error;

endmodule

// File: tb/tb_ps2_tx.sv
//-----------------------------------------------------------------------------
// tb_ps2_tx - self-checking bench for ps2_tx.
//
// A behavioural PS/2 device shares the two open-drain lines with the DUT.
// Each requested byte pushes its expected outcome to a scoreboard queue. When
// the frame ends, the bits the device sampled on rising clock edges and the
// done/error pulses are compared against the popped entry. TIMEOUT is
// shortened so that the run stays short.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ps2_tx;

  localparam int INHIBIT = 700;
  localparam int TIMEOUT = 8000;

  typedef struct {
    logic [7:0] data;
    bit         ok;      // 1: expect done, 0: expect error
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       ce;
  logic       req;
  logic [7:0] di;
  logic       dev_ck_low;
  logic       dev_da_low;
  logic       pin_ck, pin_da;
  logic       ps2CkOe, ps2DaOe, busy, done, error;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_done   = 0;
  int         n_err    = 0;
  int         ce_phase = 0;
  exp_t       sb_q[$];
  logic [10:0] last_samp;

  assign pin_ck = ~(ps2CkOe | dev_ck_low);
  assign pin_da = ~(ps2DaOe | dev_da_low);

  ps2_tx #(.INHIBIT(INHIBIT), .TIMEOUT(TIMEOUT)) dut (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .ps2Ck   (pin_ck),
    .ps2Da   (pin_da),
    .ps2CkOe (ps2CkOe),
    .ps2DaOe (ps2DaOe),
    .req     (req),
    .di      (di),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clock = ~clock;

  // ce is high on three clocks out of four. It changes 2 ns after the edge,
  // so it is stable at the next edge.
  initial begin
    ce = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      ce_phase = ce_phase + 1;
      ce = ((ce_phase % 4) != 3);
    end
  end

  // Count done/error periods, sampled once per ce tick.
  always @(posedge clock) begin
    if (ce === 1'b1) begin
      #1;
      if (done === 1'b1)  n_done++;
      if (error === 1'b1) n_err++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1);
  end

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic p;
    p = (($countones(d) % 2) == 0);
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One ce tick, then settle 1 ns past the edge.
  task automatic tick();
    do @(posedge clock); while (ce !== 1'b1);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_req(input logic [7:0] d);
    req = 1'b1;
    di  = d;
    tick();
    req = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_ckoe", ps2CkOe, 1);
    check("accept_daoe", ps2DaOe, 0);
  endtask

  // Tick indices are counted from the accepting edge (index 0).
  task automatic wait_release();
    int t, da_t, rel_t, ck_only;
    t = 0; da_t = -1; rel_t = -1; ck_only = 1;
    while (t < INHIBIT + 50) begin
      tick();
      t++;
      if (ps2DaOe === 1'b1 && da_t < 0) da_t = t;
      if (ps2CkOe === 1'b0) begin
        rel_t = t;
        break;
      end
      if (ps2CkOe === 1'b1 && ps2DaOe === 1'b0) ck_only++;
    end
    check("inhibit_ticks", ck_only, INHIBIT);
    check("start_bit_tick", da_t, INHIBIT);
    check("release_tick", rel_t, INHIBIT + 1);
    if (rel_t < 0) begin
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $fatal(1);
    end
  endtask

  // Device side: sample the start bit, then clock n_pulses pulses. It samples
  // data just before each rising edge and acks on pulse 11 unless nack is set.
  task automatic device_frame(input int half, input bit nack, input bit poke,
                              input int n_pulses);
    logic [10:0] samp;
    samp = '0;
    wait_ticks(half);
    samp[0] = pin_da;
    for (int p = 1; p <= n_pulses; p++) begin
      if (p == 11 && !nack) begin
        dev_da_low = 1'b1;
        wait_ticks(half / 2);
      end
      dev_ck_low = 1'b1;
      if (poke && p == 3) begin
        req = 1'b1;
        di  = 8'h55;
        tick();
        req = 1'b0;
        wait_ticks(half - 1);
      end else begin
        wait_ticks(half);
      end
      if (p <= 10) samp[p] = pin_da;
      dev_ck_low = 1'b0;
      if (p == 11) dev_da_low = 1'b0;
      else         wait_ticks(half);
    end
    last_samp = samp;
  endtask

  task automatic send_frame(input logic [7:0] d, input int half, input bit nack,
                            input bit poke);
    exp_t e;
    int   d0, e0, n;
    e.data = d;
    e.ok   = !nack;
    sb_q.push_back(e);
    d0 = n_done;
    e0 = n_err;
    start_req(d);
    wait_release();
    device_frame(half, nack, poke, 11);
    n = 0;
    while (busy === 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("busy_fall_ticks_le3", (n <= 3), 1);
    check("end_ckoe", ps2CkOe, 0);
    check("end_daoe", ps2DaOe, 0);
    e = sb_q.pop_front();
    check("frame_bits", last_samp, frame_of(e.data));
    check("done_count", n_done - d0, e.ok ? 1 : 0);
    check("error_count", n_err - e0, e.ok ? 0 : 1);
  endtask

  initial begin
    int n, d0, e0;
    exp_t e;

    reset      = 1'b0;
    req        = 1'b0;
    di         = 8'h00;
    dev_ck_low = 1'b0;
    dev_da_low = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("rst_ckoe", ps2CkOe, 0);
    check("rst_daoe", ps2DaOe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset = 1'b1;
    wait_ticks(4);

    // 0xF4 at about 12 kHz device clock (half period 290 ticks).
    send_frame(8'hF4, 290, 1'b0, 1'b0);
    check("f4_bits_literal", last_samp, 11'b101_1110_1000);

    // 0xED: inhibit timing is checked inside; parity must be 1.
    send_frame(8'hED, 40, 1'b0, 1'b0);
    check("ed_parity", last_samp[9], 1);

    // NACK: the device leaves data high on the 11th clock.
    send_frame(8'hF0, 40, 1'b1, 1'b0);
    check("nack_busy", busy, 0);

    // Timeout: the device never clocks after release.
    e.data = 8'h3C;
    e.ok   = 1'b0;
    sb_q.push_back(e);
    d0 = n_done;
    e0 = n_err;
    start_req(8'h3C);
    wait_release();
    n = 0;
    while (n < TIMEOUT + 50) begin
      tick();
      n++;
      if (error === 1'b1) break;
    end
    check("timeout_ticks", n, TIMEOUT);
    check("timeout_ckoe", ps2CkOe, 0);
    check("timeout_daoe", ps2DaOe, 0);
    check("timeout_busy", busy, 0);
    e = sb_q.pop_front();
    check("timeout_done_count", n_done - d0, e.ok ? 1 : 0);
    check("timeout_error_count", n_err - e0, e.ok ? 0 : 1);
    tick();
    check("timeout_error_one_tick", error, 0);

    // Reset during bit 4 of 0xFF, applied on an edge where ce=0.
    start_req(8'hFF);
    wait_release();
    device_frame(40, 1'b0, 1'b0, 4);
    dev_ck_low = 1'b1;
    wait_ticks(40);
    check("midframe_busy", busy, 1);
    do @(negedge clock); while (ce !== 1'b0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_ckoe", ps2CkOe, 0);
    check("midrst_daoe", ps2DaOe, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_error", error, 0);
    dev_ck_low = 1'b0;
    reset = 1'b1;
    wait_ticks(4);
    send_frame(8'h00, 40, 1'b0, 1'b0);
    check("zero_parity", last_samp[9], 1);

    // A req of 0x55 while busy with 0xAA is ignored.
    send_frame(8'hAA, 40, 1'b0, 1'b1);
    wait_ticks(20);
    check("no_restart_busy", busy, 0);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
